trojan_response_checker: RTL and testbench
==========================================

# trojan_response_checker

Hardware response checker that consumes the exhaustive (input vector, DUT output) stream produced by our benchmark stimulus sequencing and judges it against a golden truth table. It sits at the capture end of the trojan-detection flow: the stimulus side walks `N` from all-zeros to all-ones, and this block reads each vector/response pair. It counts mismatches, records the first failing vector and raises a pass/fail verdict after the final vector. It turns the per-benchmark text dumps into an on-the-fly, synthesizable check.

## Interface
- `N_WIDTH`, 3, width of the DUT input vector; the sweep covers 2**N_WIDTH vectors.
- `CNT_W`, 8, width of the mismatch counter.

- `CK`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a sweep; honoured in IDLE and DONE only.
- `golden`  in  2**N_WIDTH  expected output; bit i is the correct response to vector i. Must be held stable from `start` until `done`.
- `vec_valid`  in  1  a vector/response pair is present.
- `vec`  in  N_WIDTH  applied input vector.
- `dut_out`  in  1  DUT response (`output_single`) for `vec`.
- `vec_ready`  out  1  the checker accepts a pair this cycle.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid when `done` is high; 1 means zero mismatches and zero order errors.
- `mismatch_cnt`  out  CNT_W  number of mismatching pairs; saturates.
- `first_fail_vec`  out  N_WIDTH  vector of the first mismatch.
- `first_fail_valid`  out  1  `first_fail_vec` holds a captured value.
- `order_err`  out  1  sticky; set when an accepted vector differs from the expected index.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --accept of index 2**N_WIDTH-1--> DONE.
  - DONE --start--> RUN.
- Entering RUN clears the following: expected index, `mismatch_cnt`, `first_fail_*`, `order_err`, `pass`.
- `vec_ready` = (state == RUN). An accept is `vec_valid && vec_ready`.
- On each accept:
  - Mismatch when `dut_out != golden[vec]`. The response is checked against the vector actually applied.
  - `mismatch_cnt` increments and saturates at 2**CNT_W-1.
  - On the first mismatch, capture `vec` into `first_fail_vec` and set `first_fail_valid`.
  - If `vec != idx`, set `order_err`.
  - The expected index `idx` increments with wrap.
- The sweep ends on the accept where `idx == 2**N_WIDTH-1`, regardless of the value of `vec`.
- `pass` = (`mismatch_cnt` == 0) && !`order_err`. It is evaluated including the final pair.
- `start` in RUN is ignored. `vec_valid` outside RUN is ignored.

## Timing
- Reset values:
  - state = IDLE
  - `vec_ready`, `busy`, `done`, `pass`, `first_fail_valid`, `order_err` = 0
  - `mismatch_cnt` = 0, `first_fail_vec` = 0
- `start` at edge k: `busy` = 1 and `vec_ready` = 1 from cycle k+1.
- Accept at edge k: `mismatch_cnt`, `first_fail_*` and `order_err` are updated from cycle k+1 (1-cycle latency).
- Final accept at edge k: `done` = 1, `busy` = 0 and `vec_ready` = 0 from cycle k+1. `pass` is valid in the same cycle.
- `done` and the results hold until the next `start` or `reset`.
- `reset` has priority over all other inputs in any state, including mid-sweep. All outputs return to their reset values on the next cycle.
- Back-to-back accepts on every cycle are supported. Gaps in `vec_valid` add no state.

## Configuration
- `TROJAN_CHK_MISR_EN` defined:
  - Adds output `signature` [15:0], reset value 16'h0000, cleared on entering RUN.
  - On each accept: `signature <= {signature[14:0],1'b0} ^ (signature[15] ? 16'h1021 : 16'h0) ^ {vec, dut_out}`, with `{vec, dut_out}` zero-extended to 16 bits.
  - The final value is valid with `done` and allows compact comparison against stored signatures.
- `TROJAN_CHK_MISR_EN` undefined:
  - No `signature` port and no MISR logic.
  - All other behaviour is identical.

## Test plan
- Clean parity sweep:
  - Stimulus: `golden` = 8'h96 (3-input parity), `start`, vectors 0..7 with correct `dut_out`, `vec_valid` high continuously.
  - Response: `done` 8 cycles after the first accept, `pass` = 1, `mismatch_cnt` = 0, `first_fail_valid` = 0.
- Trojan hit:
  - Stimulus: `golden` = 8'h96; `dut_out` inverted at vectors 3 and 6.
  - Response: `mismatch_cnt` = 2, `first_fail_vec` = 3'b011, `pass` = 0.
- Order error and gaps:
  - Stimulus: 8 pairs with vectors 2 and 1 swapped and `vec_valid` deasserted for 3 cycles mid-sweep.
  - Response: `order_err` = 1, `pass` = 0, `done` after the 8th accept.
- Reset mid-sweep, then restart:
  - Stimulus: `reset` after 4 accepts; then `start` and a clean sweep.
  - Response: all outputs at reset values one cycle after `reset`; the second sweep gives `pass` = 1.
- Saturation and ignored start:
  - Stimulus: `CNT_W` = 2, all 8 responses wrong; `start` pulsed during RUN.
  - Response: `mismatch_cnt` = 3, the sweep is unaffected, `done` after 8 accepts.
- MISR (with `TROJAN_CHK_MISR_EN`):
  - Stimulus: the clean parity sweep, repeated twice.
  - Response: identical nonzero `signature` both times. Flipping `dut_out` at vector 5 changes `signature`.

Source files
------------

// File: rtl/trojan_response_checker.sv
// Response checker: judges an exhaustive vector/response sweep against a golden truth table.
// Optional MISR signature output is enabled with `define TROJAN_CHK_MISR_EN.
module trojan_response_checker #(
    parameter int N_WIDTH = 3,
    parameter int CNT_W   = 8
) (
    input  logic                    CK,
    input  logic                    reset,
    input  logic                    start,
    input  logic [2**N_WIDTH-1:0]   golden,
    input  logic                    vec_valid,
    input  logic [N_WIDTH-1:0]      vec,
    input  logic                    dut_out,
    output logic                    vec_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [CNT_W-1:0]        mismatch_cnt,
    output logic [N_WIDTH-1:0]      first_fail_vec,
    output logic                    first_fail_valid,
    output logic                    order_err
`ifdef TROJAN_CHK_MISR_EN
    ,
    output logic [15:0]             signature
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [N_WIDTH-1:0]   idx;
    logic                 accept;
    logic                 enter_run;
    logic                 mismatch;
    logic                 last;

    always_comb begin
        accept    = vec_valid && (state == RUN);
        enter_run = start && (state != RUN);
        mismatch  = (dut_out != golden[vec]);
        last      = (idx == '1);
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            state            <= IDLE;
            idx              <= '0;
            vec_ready        <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            order_err        <= 1'b0;
        end else if (enter_run) begin
            state            <= RUN;
            idx              <= '0;
            vec_ready        <= 1'b1;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            order_err        <= 1'b0;
        end else if (accept) begin
            if (mismatch && (mismatch_cnt != '1))
                mismatch_cnt <= mismatch_cnt + 1'b1;
            if (mismatch && !first_fail_valid) begin
                first_fail_vec   <= vec;
                first_fail_valid <= 1'b1;
            end
            if (vec != idx)
                order_err <= 1'b1;
            idx <= idx + 1'b1;
            if (last) begin
                state     <= DONE;
                vec_ready <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
                // Verdict folds in the final pair, whose effects are not yet registered
                pass      <= (mismatch_cnt == '0) && !mismatch && !order_err && (vec == idx);
            end
        end
    end

`ifdef TROJAN_CHK_MISR_EN
    logic [15:0] misr_in;

    always_comb begin
        misr_in              = '0;
        misr_in[N_WIDTH:0]   = {vec, dut_out};
    end

    always_ff @(posedge CK) begin
        if (reset || enter_run)
            signature <= '0;
        else if (accept)
            signature <= {signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000) ^ misr_in;
    end
`endif

endmodule

// File: tb/tb_trojan_response_checker.sv
// Directed bench with a scoreboard of expected post-accept results; runs CNT_W=8 and CNT_W=2 copies.
module tb_trojan_response_checker;

    logic       CK = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] golden;
    logic       vec_valid;
    logic [2:0] vec;
    logic       dut_out;

    logic       vec_ready, busy, done, pass, first_fail_valid, order_err;
    logic [7:0] mismatch_cnt;
    logic [2:0] first_fail_vec;

    logic       vec_ready2, busy2, done2, pass2, first_fail_valid2, order_err2;
    logic [1:0] mismatch_cnt2;
    logic [2:0] first_fail_vec2;

`ifdef TROJAN_CHK_MISR_EN
    logic [15:0] signature, signature2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CK = ~CK;

    trojan_response_checker #(.N_WIDTH(3), .CNT_W(8)) dut (
        .CK(CK), .reset(reset), .start(start), .golden(golden),
        .vec_valid(vec_valid), .vec(vec), .dut_out(dut_out),
        .vec_ready(vec_ready), .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .first_fail_vec(first_fail_vec),
        .first_fail_valid(first_fail_valid), .order_err(order_err)
`ifdef TROJAN_CHK_MISR_EN
        , .signature(signature)
`endif
    );

    trojan_response_checker #(.N_WIDTH(3), .CNT_W(2)) dut2 (
        .CK(CK), .reset(reset), .start(start), .golden(golden),
        .vec_valid(vec_valid), .vec(vec), .dut_out(dut_out),
        .vec_ready(vec_ready2), .busy(busy2), .done(done2), .pass(pass2),
        .mismatch_cnt(mismatch_cnt2), .first_fail_vec(first_fail_vec2),
        .first_fail_valid(first_fail_valid2), .order_err(order_err2)
`ifdef TROJAN_CHK_MISR_EN
        , .signature(signature2)
`endif
    );

    typedef struct {
        logic [7:0]  cnt8;
        logic [1:0]  cnt2;
        logic        ffvalid;
        logic [2:0]  ffv;
        logic        oerr;
        logic        done;
        logic        busy;
        logic        pass;
        logic [15:0] sig;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;
    mstate_t     m_state;
    int          m_cnt8, m_cnt2, m_idx;
    logic        m_ffvalid, m_oerr, m_pass;
    logic [2:0]  m_ffv;
    logic [15:0] m_sig;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt8 = 0; m_cnt2 = 0; m_idx = 0;
        m_ffvalid = 1'b0; m_oerr = 1'b0; m_pass = 1'b0; m_ffv = 3'd0; m_sig = 16'h0000;
    endtask

    task automatic push_exp();
        exp_t e;
        e.cnt8 = 8'(m_cnt8); e.cnt2 = 2'(m_cnt2);
        e.ffvalid = m_ffvalid; e.ffv = m_ffv; e.oerr = m_oerr;
        e.done = (m_state == M_DONE); e.busy = (m_state == M_RUN);
        e.pass = m_pass; e.sig = m_sig;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, "_cnt"},     32'(mismatch_cnt),     32'(e.cnt8));
        check({tag, "_cnt2"},    32'(mismatch_cnt2),    32'(e.cnt2));
        check({tag, "_ffvalid"}, 32'(first_fail_valid), 32'(e.ffvalid));
        check({tag, "_ffv"},     32'(first_fail_vec),   32'(e.ffv));
        check({tag, "_oerr"},    32'(order_err),        32'(e.oerr));
        check({tag, "_done"},    32'(done),             32'(e.done));
        check({tag, "_done2"},   32'(done2),            32'(e.done));
        check({tag, "_busy"},    32'(busy),             32'(e.busy));
        check({tag, "_ready"},   32'(vec_ready),        32'(e.busy));
        if (e.done)
            check({tag, "_pass"}, 32'(pass), 32'(e.pass));
`ifdef TROJAN_CHK_MISR_EN
        check({tag, "_sig"}, 32'(signature), 32'(e.sig));
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; vec_valid = 1'b0;
        @(posedge CK); #1;
        reset = 1'b0;
        m_state = M_IDLE; model_clear();
        push_exp();
        pop_check("reset");
        check("reset_pass", 32'(pass), 32'd0);
        check("reset_pass2", 32'(pass2), 32'd0);
        check("reset_ready2", 32'(vec_ready2), 32'd0);
    endtask

    task automatic do_start();
        start = 1'b1; vec_valid = 1'b0;
        @(posedge CK); #1;
        start = 1'b0;
        if (m_state != M_RUN) begin
            m_state = M_RUN; model_clear();
        end
        push_exp();
        pop_check("start");
        check("start_pass", 32'(pass), 32'd0);
    endtask

    // Drive one pair for a cycle; flip inverts the correct response; st also pulses start
    task automatic send(input logic [2:0] v, input logic flip, input logic st, input string tag);
        logic d;
        d = golden[v] ^ flip;
        vec = v; dut_out = d; vec_valid = 1'b1; start = st;
        if (m_state == M_RUN) begin
            if (d != golden[v]) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
                if (!m_ffvalid) begin m_ffvalid = 1'b1; m_ffv = v; end
            end
            if (int'(v) != m_idx) m_oerr = 1'b1;
            m_sig = {m_sig[14:0], 1'b0} ^ (m_sig[15] ? 16'h1021 : 16'h0000) ^ {12'd0, v, d};
            if (m_idx == 7) begin
                m_state = M_DONE;
                m_pass = (m_cnt8 == 0) && !m_oerr;
            end
            m_idx = (m_idx + 1) % 8;
        end else if (st) begin
            m_state = M_RUN; model_clear();
        end
        push_exp();
        @(posedge CK); #1;
        vec_valid = 1'b0; start = 1'b0;
        pop_check(tag);
    endtask

    task automatic gap();
        vec_valid = 1'b0;
        push_exp();
        @(posedge CK); #1;
        pop_check("gap");
    endtask

    task automatic sweep(input logic [7:0] flips, input string tag);
        for (int i = 0; i < 8; i++)
            send(3'(i), flips[i], 1'b0, tag);
    endtask

`ifdef TROJAN_CHK_MISR_EN
    logic [15:0] clean_sig;
`endif

    initial begin
        golden = 8'h96; vec = 3'd0; dut_out = 1'b0; vec_valid = 1'b0; start = 1'b0;
        m_state = M_IDLE; model_clear();
        do_reset();
        do_reset();

        // Clean parity sweep
        do_start();
        sweep(8'h00, "clean");
        check("clean_pass_final", 32'(pass), 32'd1);
        // Pairs offered in DONE must be ignored
        send(3'd0, 1'b1, 1'b0, "done_ignore");

        // Trojan hit at vectors 3 and 6
        do_start();
        sweep(8'b0100_1000, "trojan");
        check("trojan_cnt_final", 32'(mismatch_cnt), 32'd2);
        check("trojan_ffv_final", 32'(first_fail_vec), 32'd3);

        // Order error with a 3-cycle gap
        do_start();
        send(3'd0, 1'b0, 1'b0, "order");
        send(3'd2, 1'b0, 1'b0, "order");
        send(3'd1, 1'b0, 1'b0, "order");
        send(3'd3, 1'b0, 1'b0, "order");
        gap(); gap(); gap();
        for (int i = 4; i < 8; i++)
            send(3'(i), 1'b0, 1'b0, "order");
        check("order_oerr_final", 32'(order_err), 32'd1);

        // Reset mid-sweep, then a clean restart
        do_start();
        for (int i = 0; i < 4; i++)
            send(3'(i), i == 1, 1'b0, "pre_reset");
        do_reset();
        do_start();
        sweep(8'h00, "restart");
        check("restart_pass_final", 32'(pass), 32'd1);

        // All wrong with start pulsed mid-RUN: CNT_W=2 copy saturates at 3
        do_start();
        for (int i = 0; i < 8; i++)
            send(3'(i), 1'b1, i == 3, "sat");
        check("sat_cnt2_final", 32'(mismatch_cnt2), 32'd3);
        check("sat_cnt8_final", 32'(mismatch_cnt), 32'd8);
        check("sat_pass2_final", 32'(pass2), 32'd0);

`ifdef TROJAN_CHK_MISR_EN
        do_start();
        sweep(8'h00, "misr_a");
        clean_sig = m_sig;
        do_start();
        sweep(8'h00, "misr_b");
        check("misr_repeat", 32'(signature), 32'(clean_sig));
        checks++;
        assert (signature !== 16'h0000) else begin
            errors++; $error("FAIL misr_nonzero observed=%0h expected=nonzero", signature);
        end
        do_start();
        sweep(8'b0010_0000, "misr_flip");
        checks++;
        assert (signature !== clean_sig) else begin
            errors++; $error("FAIL misr_flip_diff observed=%0h expected=not %0h", signature, clean_sig);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
